// File: rtl/tt_calc_entry.sv
// Operand-entry sequencer for the 4-bit calculator ALU: synchronises and debounces
// ENTER/CLEAR, then captures A, B and the opcode in turn from a shared switch bank.
module tt_calc_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [1:0] op_out,
  output logic       operands_valid,
  output logic [1:0] state_out
);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_OP   = 2'b10;
  localparam logic [1:0] S_SHOW = 2'b11;

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

  // Bit 0 is ENTER, bit 1 is CLEAR throughout the button path.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_q;
  logic [7:0] cnt [2];
  logic       enter_ev;
  logic       clear_ev;
  logic [1:0] state;

  assign raw = {btn_clear, btn_enter};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      deb    <= 2'b00;
      deb_q  <= 2'b00;
      cnt[0] <= 8'd0;
      cnt[1] <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= 8'd0;
        end else if (cnt[i] + 8'd1 == LIMIT) begin
          deb[i] <= sync2[i];
          cnt[i] <= 8'd0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Press events are the debounced rising edge; releases are ignored.
  assign enter_ev = deb[0] & ~deb_q[0];
  assign clear_ev = deb[1] & ~deb_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_A;
      a_out          <= 4'd0;
      b_out          <= 4'd0;
      op_out         <= 2'd0;
      operands_valid <= 1'b0;
    end else begin
      operands_valid <= 1'b0;
      if (clear_ev) begin
        state  <= S_A;
        a_out  <= 4'd0;
        b_out  <= 4'd0;
        op_out <= 2'd0;
      end else if (enter_ev) begin
        case (state)
          S_A: begin
            a_out <= sw_in;
            state <= S_B;
          end
          S_B: begin
            b_out <= sw_in;
            state <= S_OP;
          end
          S_OP: begin
            op_out         <= sw_in[1:0];
            operands_valid <= 1'b1;
            state          <= S_SHOW;
          end
          default: begin
            a_out <= sw_in;
            state <= S_B;
          end
        endcase
      end
    end
  end

  assign state_out = state;

endmodule

// File: doc/tt_calc_entry.md
# tt_calc_entry

Operand-entry sequencer sitting directly upstream of the 4-bit calculator ALU in the TinyTapeout design. It takes a shared 4-bit switch bank plus two raw push-buttons (ENTER, CLEAR), synchronises and debounces the buttons, and walks a state machine that captures operand A, operand B and the 2-bit opcode in turn. Captured values are held stable on dedicated outputs that drive the ALU's A/B/op inputs directly, with a one-cycle valid strobe when a complete operation has been entered.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button level is accepted; legal range 2..255.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `sw_in` input 4: switch bank; sampled as A, as B, or (bits [1:0]) as the opcode, depending on state. Static, not synchronised.
- `btn_enter` input 1: raw ENTER button, active-high, asynchronous to clk.
- `btn_clear` input 1: raw CLEAR button, active-high, asynchronous to clk.
- `a_out` output 4: captured operand A.
- `b_out` output 4: captured operand B.
- `op_out` output 2: captured opcode (00 add, 01 sub, 10 mul, 11 and).
- `operands_valid` output 1: one-cycle pulse; `a_out`/`b_out`/`op_out` form a new complete operation.
- `state_out` output 2: current FSM state encoding, for status LEDs.

## Operation
- **Reset values** (while `rst_n` = 0): `a_out` = 0, `b_out` = 0, `op_out` = 0, `operands_valid` = 0, `state_out` = 00. Synchronisers, debounced levels and counters are all cleared.
- **Synchroniser:** each button passes through a 2-flop synchroniser.
- **Debouncer (per button):**
  - 8-bit counter. It clears on any cycle where the synchronised level equals the debounced level, and increments otherwise.
  - When it would reach `DEBOUNCE_CYCLES`, the debounced level takes the synchronised level and the counter clears.
- **Events:** a press event is the debounced rising edge, asserted for exactly one cycle. Release produces no event. A held button produces exactly one event.
- **FSM states** (encoding on `state_out`):
  - S_A (00), on enter: `a_out` <= `sw_in`, go to S_B.
  - S_B (01), on enter: `b_out` <= `sw_in`, go to S_OP.
  - S_OP (10), on enter: `op_out` <= `sw_in[1:0]`, `operands_valid` = 1 for the following cycle, go to S_SHOW.
  - S_SHOW (11), on enter: `a_out` <= `sw_in`, go to S_B. `b_out`/`op_out` keep their old values until overwritten.
- **Clear event:** from any state, go to S_A and zero `a_out`, `b_out` and `op_out`.
  - A clear event in the same cycle as an enter event takes precedence; the enter event is discarded.
- **Holding:** outputs change only on capture, clear or reset. They are registered and glitch-free.
- **`operands_valid`:** registered, asserted for exactly one cycle per completed entry, never on clear or reset.
- **Mid-operation reset:** `rst_n` low at any time returns everything to reset values immediately. A button held through reset deassertion produces one event once it has been stable for `DEBOUNCE_CYCLES`.

## Timing
- **Press latency:** raw button goes high before rising edge E0 and stays high. The synchronised level is high after E1. The counter increments at E2..E(D+1), where D = `DEBOUNCE_CYCLES`, and the debounced level rises at E(D+1). The capture register updates at E(D+2).
  - Total latency: D+2 edges from E0 to updated output.
- **`operands_valid` timing:** high in the cycle following the E(D+2) edge that loads `op_out`, i.e. coincident with the new `op_out`.
- **Glitch rejection:** any raw pulse whose synchronised width is shorter than D cycles produces no event.
- **Back-to-back entries:** minimum spacing between events is 2D+2 cycles (press plus release debounce); there is no other throughput limit.
- **`sw_in` sampling:** sampled only on the capture edge, and must be stable for that edge.

## Test plan
1. **Full entry**, D=4: A=5 enter, B=3 enter, op=10 enter.
   - `a_out`=5, `b_out`=3, `op_out`=10.
   - `operands_valid` high exactly 1 cycle, 6 edges after the third press.
   - `state_out` steps 00→01→10→11.
2. **Glitch rejection:** 3-cycle ENTER pulse with D=4 gives no state change. A 1-cycle gap inside a long press gives a single event.
3. **Clear mid-entry:** after A=9 captured, press CLEAR.
   - `state_out`=00 and all outputs 0, no valid pulse.
   - Next ENTER with `sw_in`=2 gives `a_out`=2.
4. **Simultaneous events:** ENTER and CLEAR rising on the same edge in S_B gives S_A, outputs 0, `b_out` not loaded.
5. **Re-entry from S_SHOW:** `sw_in`=7 ENTER gives `a_out`=7, `state_out`=01, `b_out`/`op_out` unchanged, no valid pulse.
6. **Reset mid-debounce:** assert `rst_n`=0 with counter at 2.
   - All outputs are 0 immediately.
   - With ENTER still held after release of reset, exactly one capture occurs D+2 edges later.
